// File: rtl/uart_pkg.sv
// Shared UART package: state encoding, default data width and parity helper.
// Parity support in uart_tx is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    // Data bits per frame shared by the transmitter and the receiver.
    localparam int UART_DATAWIDTH = 8;

    // Frame state encoding; ST_PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity of a word of up to 9 bits; narrower words are zero-extended.
    function automatic logic even_parity(input logic [8:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and asserts tick on the last count.
// A synchronous clear restarts the count so bit boundaries align to a start bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // Next count: restart on clear or at the end of a bit, otherwise advance.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Count register; reset arrives through clr.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from a first-word-fall-through FIFO and sends
// idle-high frames (start, LSB-first data, optional even parity, one stop bit).
// Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATAWIDTH    = UART_DATAWIDTH,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ISEMPTY,
    input  logic [DATAWIDTH-1:0] DATA,
    output logic                 READ,
    output logic                 TX,
    output logic                 BUSY
);

    localparam int BW = $clog2(DATAWIDTH);

    uart_state_e          state_q, state_d;
    logic [DATAWIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]        bitcnt_q, bitcnt_d;
    logic                 tx_q, tx_d;
    logic                 read_q, read_d;
    logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif
    logic                 load;
    logic                 tick;

    // Bit boundaries restart on every load so the start bit gets a full bit time.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (CLK),
        .clr  (RST | load),
        .tick (tick)
    );

    // Next-state and next-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        read_d   = 1'b0;
        load     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!ISEMPTY) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d  = ST_DATA;
                    bitcnt_d = '0;
                    tx_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bitcnt_q == BW'(DATAWIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        tx_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (!ISEMPTY) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A load captures the FIFO head and starts the start bit on the next edge.
        if (load) begin
            state_d  = ST_START;
            shift_d  = DATA;
            bitcnt_d = '0;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
            read_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_d    = even_parity(9'(DATA));
`endif
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            tx_q     <= 1'b1;
            read_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            read_q   <= read_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign TX   = tx_q;
    assign READ = read_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 4 clocks per bit) fed from FIFO
// models, checked every cycle against a frame-level model plus literal frames.
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL   = DW + 2 + P;
    localparam int CPB0 = 1;
    localparam int CPB1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      isempty_w;
    logic [1:0]      read_w;
    logic [1:0]      tx_w;
    logic [1:0]      busy_w;
    logic [1:0][7:0] data_w;

    uart_tx #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPB0)) dut0 (
        .CLK(clk), .RST(rst), .ISEMPTY(isempty_w[0]), .DATA(data_w[0]),
        .READ(read_w[0]), .TX(tx_w[0]), .BUSY(busy_w[0]));

    uart_tx #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPB1)) dut1 (
        .CLK(clk), .RST(rst), .ISEMPTY(isempty_w[1]), .DATA(data_w[1]),
        .READ(read_w[1]), .TX(tx_w[1]), .BUSY(busy_w[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO models, one per instance, receiving identical pushes.
    logic [7:0] mem [2][1024];
    int rdp [2] = '{0, 0};
    int wrp [2] = '{0, 0};

    task automatic push(input logic [7:0] w);
        for (int i = 0; i < 2; i++) begin
            mem[i][wrp[i] % 1024] = w;
            wrp[i]++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (read_w[i] === 1'b1 && rdp[i] < wrp[i]) rdp[i]++;
            isempty_w[i] = (rdp[i] == wrp[i]);
            data_w[i]    = isempty_w[i] ? 8'($urandom) : mem[i][rdp[i] % 1024];
        end
    endtask

    // Bits of one frame in send order, index 0 = start bit.
    function automatic logic [15:0] frame_bits(input logic [7:0] w);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int j = 0; j < DW; j++) f[1 + j] = w[j];
        if (P == 1) f[DW + 1] = ^w;
        return f;
    endfunction

    // Frame-level model: a frame is either running (with a cycle offset) or not.
    int          cpb [2] = '{CPB0, CPB1};
    bit          mb  [2] = '{1'b0, 1'b0};
    int          mt  [2] = '{0, 0};
    bit          mld [2] = '{1'b0, 1'b0};
    logic [15:0] mf  [2];
    int          cyc = 0;
    int          nread [2] = '{0, 0};
    int          last_read [2] = '{0, 0};
    int          read_gap [2] = '{0, 0};
    int          run [2] = '{0, 0};
    int          lastrun [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mb[i]  = 1'b0;
                mld[i] = 1'b0;
            end else if (!mb[i] || mt[i] == FL * cpb[i] - 1) begin
                mb[i]  = 1'b0;
                mld[i] = 1'b0;
                if (!isempty_w[i]) begin
                    mb[i]  = 1'b1;
                    mt[i]  = 0;
                    mld[i] = 1'b1;
                    mf[i]  = frame_bits(data_w[i]);
                end
            end else begin
                mt[i]++;
                mld[i] = 1'b0;
            end
        end
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx%0d", i), tx_w[i], mb[i] ? mf[i][mt[i] / cpb[i]] : 1'b1);
            check($sformatf("busy%0d", i), busy_w[i], mb[i]);
            check($sformatf("read%0d", i), read_w[i], mld[i]);
            if (read_w[i] === 1'b1) begin
                nread[i]++;
                read_gap[i]  = cyc - last_read[i];
                last_read[i] = cyc;
            end
            if (busy_w[i] === 1'b1) begin
                run[i]++;
            end else if (run[i] > 0) begin
                lastrun[i] = run[i];
                run[i]     = 0;
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy_w !== 2'b00 || rdp[0] != wrp[0] || rdp[1] != wrp[1]) && k < 20000) begin
            step();
            k++;
        end
        check("idle_timeout", 32'(k < 20000), 32'd1);
        step();
    endtask

    // Records instance 0's TX for one frame, starting at its next READ.
    task automatic capture(output logic [15:0] s);
        int k;
        k = 0;
        while (read_w[0] !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check("capture_start", read_w[0], 1'b1);
        s = '1;
        for (int j = 0; j < FL; j++) begin
            s[j] = tx_w[0];
            step();
        end
    endtask

    logic [15:0] s;
    int          r0;
    int          r1;

    initial begin
        rst       = 1'b1;
        isempty_w = 2'b11;
        data_w    = '0;

        // Reset held with a word waiting: nothing may leave the block.
        push(8'h5A);
        repeat (3) begin
            step();
            check("rst_tx", tx_w, 2'b11);
            check("rst_read", read_w, 2'b00);
            check("rst_busy", busy_w, 2'b00);
        end
        rst = 1'b0;
        step();
        check("first_read_after_rst", read_w, 2'b11);
        wait_idle();

        // Single byte at one clock per bit.
        r0 = nread[0];
        push(8'hA5);
        capture(s);
`ifdef UART_TX_PARITY_EN
        check("a5_frame", {16'h0, s}, 32'h0000FD4A);
`else
        check("a5_frame", {16'h0, s}, 32'h0000FF4A);
`endif
        wait_idle();
        check("a5_reads", nread[0] - r0, 1);

        // Baud scaling: BUSY length for 1 and 4 clocks per bit.
        push(8'h3C);
        wait_idle();
        check("busy_len_cpb1", lastrun[0], FL);
        check("busy_len_cpb4", lastrun[1], FL * 4);
        check("frame_len_literal", lastrun[0], (P == 1) ? 11 : 10);

        // Back-to-back frames.
        r0 = nread[0];
        r1 = nread[1];
        push(8'h01);
        push(8'h80);
        wait_idle();
        check("b2b_reads0", nread[0] - r0, 2);
        check("b2b_reads1", nread[1] - r1, 2);
        check("b2b_gap0", read_gap[0], FL);
        check("b2b_gap1", read_gap[1], FL * 4);
        check("b2b_busy0", lastrun[0], 2 * FL);

`ifdef UART_TX_PARITY_EN
        // Parity bit values.
        push(8'h07);
        capture(s);
        check("parity_07", s[DW + 1], 1'b1);
        wait_idle();
        push(8'h03);
        capture(s);
        check("parity_03", s[DW + 1], 1'b0);
        wait_idle();
`endif

        // Reset during data bit 4 of 8'hFF, then a clean frame.
        push(8'hFF);
        begin
            int k;
            k = 0;
            while (read_w[0] !== 1'b1 && k < 50) begin
                step();
                k++;
            end
            check("ff_start", read_w[0], 1'b1);
        end
        repeat (5) step();
        check("ff_busy_mid", busy_w, 2'b11);
        rst = 1'b1;
        push(8'h42);
        step();
        check("midrst_tx", tx_w, 2'b11);
        check("midrst_busy", busy_w, 2'b00);
        check("midrst_read", read_w, 2'b00);
        step();
        check("midrst_read2", read_w, 2'b00);
        rst = 1'b0;
        capture(s);
`ifdef UART_TX_PARITY_EN
        check("post_rst_frame", {16'h0, s}, 32'h0000FC84);
`else
        check("post_rst_frame", {16'h0, s}, 32'h0000FE84);
`endif
        wait_idle();

        // Random traffic with occasional one-cycle resets.
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) push(8'($urandom));
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
